// File: rtl/pe_row_feeder.sv
// Left-edge X feeder for a ROWS-high PE array: vector FIFO, burst FSM and per-row skew line.
// Optional macro FEEDER_BUBBLE_CNT_EN enables the FEED-state bubble counter on O_BUBBLE_CNT.
module pe_row_feeder #(
    parameter int ROWS  = 4,
    parameter int DW    = 16,
    parameter int DEPTH = 4,
    parameter int LENW  = 8
) (
    input  logic                 I_CLK,
    input  logic                 I_RST_N,
    input  logic                 I_VEC_VLD,
    input  logic [ROWS*DW-1:0]   I_VEC,
    output logic                 O_VEC_RDY,
    input  logic                 I_START,
    input  logic [LENW-1:0]      I_LEN,
    input  logic                 I_STALL,
    output logic [ROWS-1:0]      O_X_VLD,
    output logic [ROWS*DW-1:0]   O_X,
    output logic                 O_BUSY,
    output logic                 O_DONE,
    output logic [LENW-1:0]      O_BUBBLE_CNT
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = (ROWS > 2) ? $clog2(ROWS - 1) : 1;
    localparam logic [FW-1:0] FLUSH_LAST = FW'((ROWS > 1) ? ROWS - 2 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FEED,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t state_q, state_d;
    logic [LENW-1:0] len_q, len_d;
    logic [LENW-1:0] issued_q, issued_d;
    logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
    logic            done_q, done_d;

    logic [ROWS*DW-1:0] fifo_mem [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               start_acc;
    logic [ROWS*DW-1:0] fifo_head;

    assign fifo_full  = (count_q == (AW+1)'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign O_VEC_RDY  = !fifo_full;
    assign push       = I_VEC_VLD && !fifo_full;
    assign pop        = (state_q == ST_FEED) && !I_STALL && !fifo_empty;
    assign start_acc  = (state_q == ST_IDLE) && !I_STALL && I_START;
    assign fifo_head  = fifo_mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the cleared pointers make stale entries unreachable.
    always_ff @(posedge I_CLK) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= I_VEC;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        issued_d    = issued_q;
        flush_cnt_d = flush_cnt_q;
        if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
        end else if (!I_STALL) begin
            case (state_q)
                ST_IDLE: begin
                    if (I_START) begin
                        len_d    = I_LEN;
                        issued_d = '0;
                        state_d  = (I_LEN == '0) ? ST_DONE : ST_FEED;
                    end
                end
                ST_FEED: begin
                    if (pop) begin
                        issued_d = issued_q + LENW'(1);
                        if (issued_q + LENW'(1) == len_q) begin
                            flush_cnt_d = '0;
                            state_d     = (ROWS == 1) ? ST_DONE : ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_q == FLUSH_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        flush_cnt_d = flush_cnt_q + FW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            issued_q    <= '0;
            flush_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            flush_cnt_q <= flush_cnt_d;
            done_q      <= done_d;
        end
    end

    assign O_BUSY = (state_q != ST_IDLE);
    assign O_DONE = done_q;

`ifdef FEEDER_BUBBLE_CNT_EN
    logic [LENW-1:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (start_acc) begin
            bubble_cnt_d = '0;
        end else if ((state_q == ST_FEED) && !I_STALL && fifo_empty && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + LENW'(1);
        end
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign O_BUBBLE_CNT = bubble_cnt_q;
`else
    assign O_BUBBLE_CNT = '0;
`endif

    // Row r owns stages 0..r; stage r is its output register, so lane r lags row 0 by r cycles.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [r:0]         vld_q, vld_d;
        logic [r:0][DW-1:0] dat_q, dat_d;

        assign vld_d[0] = I_STALL ? vld_q[0] : pop;
        assign dat_d[0] = I_STALL ? dat_q[0] : (pop ? fifo_head[r*DW +: DW] : '0);

        for (genvar s = 1; s <= r; s++) begin : g_stage
            assign vld_d[s] = I_STALL ? vld_q[s] : vld_q[s-1];
            assign dat_d[s] = I_STALL ? dat_q[s] : dat_q[s-1];
        end

        always_ff @(posedge I_CLK or negedge I_RST_N) begin
            if (!I_RST_N) begin
                vld_q <= '0;
                dat_q <= '0;
            end else begin
                vld_q <= vld_d;
                dat_q <= dat_d;
            end
        end

        assign O_X_VLD[r]        = vld_q[r] && !I_STALL;
        assign O_X[r*DW +: DW]   = dat_q[r];
    end

endmodule

// File: doc/pe_row_feeder.md
Name: pe_row_feeder

Overview:
- Transmit side of the PE left-edge X interface. Accepts row vectors of Q2.13 samples (1 sign, 2 int, 13 frac) on a valid/ready handshake and buffers them in a small FIFO.
- Injects each vector into the left column of a ROWS-high PE array as a skewed wavefront: row r is delayed r cycles relative to row 0.
- A start/length command frames each burst. O_DONE pulses once the last wavefront has left the skew line.

Parameters:
ROWS, 4, number of PE rows fed (one X lane per row)
DW, 16, sample width (Q2.13)
DEPTH, 4, vector FIFO depth, power of 2, >=2
LENW, 8, width of burst length field

Ports:
I_CLK  in  1  clock
I_RST_N  in  1  reset
I_VEC_VLD  in  1  input vector valid
I_VEC  in  ROWS*DW  input vector; lane r = bits [r*DW +: DW]
O_VEC_RDY  out  1  FIFO can accept a vector (= !full)
I_START  in  1  burst start pulse, sampled in IDLE only
I_LEN  in  LENW  vectors in burst, latched on accepted I_START
I_STALL  in  1  array back-pressure; freezes injection and skew line
O_X_VLD  out  ROWS  per-row X valid to PE I_X_VLD
O_X  out  ROWS*DW  per-row X to PE I_X
O_BUSY  out  1  state != IDLE
O_DONE  out  1  one-cycle burst-complete pulse
O_BUBBLE_CNT  out  LENW  bubbles inserted in current/last burst (see Optional Feature)

Behaviour:
- Reset I_RST_N, asynchronous, active-low; clock I_CLK.
- Reset values: O_X_VLD=0, O_X=0, O_DONE=0, O_BUBBLE_CNT=0, state IDLE, FIFO empty. O_VEC_RDY=1 after reset.
- FIFO:
  - Push when I_VEC_VLD & O_VEC_RDY.
  - O_VEC_RDY = !full, combinational from count; no push-through when full.
  - Simultaneous push and pop leaves count unchanged. Pointers wrap modulo DEPTH.
  - Pushes are accepted in any state.
- FSM IDLE -> FEED -> FLUSH -> DONE -> IDLE.
  - IDLE: on I_START with I_LEN!=0, latch len, clear issued counter and bubble counter, go to FEED. On I_START with I_LEN==0, go to DONE directly with no injection. I_START outside IDLE is ignored.
  - FEED, per non-stalled cycle:
    - FIFO non-empty: pop the head, load wavefront stage 0 with valid=1 and data=vector, issued++.
    - FIFO empty: load stage 0 with valid=0 and data=0, bubble++.
    - When issued reaches len (on the pop edge), go to FLUSH.
  - FLUSH: inject valid=0 for ROWS-1 non-stalled cycles (flush counter), then go to DONE. With ROWS==1, FLUSH lasts 0 cycles.
  - DONE: O_DONE=1 for exactly one cycle, then IDLE.
- Skew line:
  - Row r has an r-stage delay register chain feeding its output register.
  - Lane r of a vector popped at edge k drives O_X[r]/O_X_VLD[r] after edge k+r, absent stalls.
  - O_X_VLD[r] is high for exactly one cycle per popped vector.
- Stall:
  - While I_STALL=1, the FSM, counters, FIFO pop and all skew stages hold.
  - O_X_VLD is forced to 0 and O_X holds its last value.
  - Release resumes with no lost or duplicated samples.
  - A stall in FLUSH extends FLUSH. A stall in DONE does not delay the pulse.
- Reset mid-burst: the asynchronous clear discards FIFO contents, skew data and counters. No O_DONE is produced.
- Data is passed unmodified; no arithmetic on samples.

Optional Feature:
- Macro FEEDER_BUBBLE_CNT_EN.
- Defined: O_BUBBLE_CNT counts FEED-state bubbles (empty FIFO, not stalled). The count saturates at 2^LENW-1, clears on accepted I_START, and holds after DONE.
- Undefined: the counter logic is absent and O_BUBBLE_CNT is tied to 0.

Test Plan:
1. ROWS=4, preload 4 vectors with lane r = 0x2000+r (then +0x10 per vector), START LEN=4, no stall -> row0 valid 4 consecutive cycles from T. Row3 valid T+3..T+6 carrying 0x2003, 0x2013, 0x2023, 0x2033. O_DONE pulses once after FLUSH. Exactly 16 valid beats total.
2. Same burst with I_STALL high 3 cycles mid-FEED -> O_X_VLD=0 during the stall. The sequence is otherwise identical, shifted by 3 cycles, with no duplicates or drops.
3. No START, push 5 vectors with DEPTH=4 -> O_VEC_RDY falls after the 4th push and the 5th is held. START LEN=4 -> RDY rises after the first pop and the 5th vector is accepted.
4. START LEN=3 with 1 vector buffered, 2nd and 3rd pushed 2 cycles later -> 2 bubble cycles on all rows. O_BUBBLE_CNT=2 with macro, 0 without. Burst completes.
5. I_START with I_LEN=0 -> O_DONE high exactly one cycle later, O_X_VLD stays 0. A START issued during FEED is ignored.
6. Assert I_RST_N low mid-FEED -> all outputs 0 immediately, O_VEC_RDY=1, no O_DONE. A new burst after release runs normally.
